serial_frame_rx: RTL and testbench

- Downstream consumer of the 16-bit SIPO-to-PISO serial chain.
- Hunts the incoming bitstream for a sync byte, then deserializes the next DATA_W bits (MSB first) into a word.
- Buffers completed words in a small FIFO and presents them on a valid/ready parallel interface.
- Tracks dropped words and counts accepted frames.

---
 rtl/serial_frame_rx.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync byte, deserializes the following
// payload MSB first and queues completed words behind a valid/ready port.
module serial_frame_rx #(
  parameter int                DATA_W     = 16,
  parameter int                SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_PAT   = 8'hA5,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            serial_in,
  input  logic                            bit_en,
  output logic [DATA_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow,
  input  logic                            clr_ovf,
  output logic [7:0]                      frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]        state_r;
  logic [SYNC_W-2:0] window_r;
  logic [DATA_W-2:0] shift_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r;
  logic              overflow_r;
  logic [7:0]        frame_cnt_r;

  logic [SYNC_W-1:0] window_nxt_s;
  logic [DATA_W-1:0] word_s;
  logic              sync_hit_s;
  logic              push_evt_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [LVL_W-1:0]  level_nxt_s;

  // Frame detection, push/pop decisions and next FIFO occupancy.
  always_comb begin
    window_nxt_s = {window_r, serial_in};
    word_s       = {shift_r, serial_in};
    sync_hit_s   = bit_en && (state_r == HUNT) && (window_nxt_s == SYNC_PAT);
    push_evt_s   = bit_en && (state_r == COLLECT) && (bit_cnt_r == CNT_W'(DATA_W - 1));
    full_s       = (level_r == LVL_W'(FIFO_DEPTH));
    pop_s        = out_valid_r && out_ready;
    push_s       = push_evt_s && (!full_s || pop_s);
    drop_s       = push_evt_s && full_s && !pop_s;
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_nxt_s = level_r - LVL_W'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Sync hunt and payload deserializer; the window restarts empty after each sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= HUNT;
      window_r  <= {(SYNC_W-1){1'b0}};
      shift_r   <= {(DATA_W-1){1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
    end else if (bit_en) begin
      case (state_r)
        HUNT: begin
          if (sync_hit_s) begin
            state_r   <= COLLECT;
            window_r  <= {(SYNC_W-1){1'b0}};
            bit_cnt_r <= {CNT_W{1'b0}};
          end else begin
            window_r  <= window_nxt_s[SYNC_W-2:0];
          end
        end
        COLLECT: begin
          shift_r <= word_s[DATA_W-2:0];
          if (push_evt_s) begin
            state_r   <= HUNT;
            bit_cnt_r <= {CNT_W{1'b0}};
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r   <= HUNT;
          bit_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Output FIFO with a registered head word (no fall-through).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      level_r     <= {LVL_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      level_r     <= level_nxt_s;
      out_valid_r <= (level_nxt_s != {LVL_W{1'b0}});
      // The new head is the incoming word only when it lands at the read pointer.
      if (level_nxt_s == {LVL_W{1'b0}}) begin
        out_data_r <= out_data_r;
      end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
        out_data_r <= word_s;
      end else begin
        out_data_r <= mem_r[rd_ptr_nxt_s];
      end
    end
  end

  // Sticky overflow (set wins over clear) and accepted-frame counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (push_s) begin
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign overflow   = overflow_r;
  assign frame_cnt  = frame_cnt_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_serial_frame_rx;

  logic        clk;
  logic        rst;
  logic        serial_in;
  logic        bit_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clr_ovf;
  logic [7:0]  frame_cnt;
  logic [2:0]  fifo_level;

  int checks;
  int errors;

  // Reference model state
  logic [15:0] m_q[$];
  bit          m_hist[$];
  bit          m_coll;
  int          m_cnt;
  logic [15:0] m_word;
  bit          m_ovf;
  int          m_fcnt;
  bit          rnd_mode;

  serial_frame_rx dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_en(bit_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .clr_ovf(clr_ovf), .frame_cnt(frame_cnt),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_hist.delete();
    m_coll = 1'b0;
    m_cnt  = 0;
    m_word = 16'h0000;
    m_ovf  = 1'b0;
    m_fcnt = 0;
  endtask

  // One clock: advance the model with the current inputs, then compare.
  task automatic tick();
    bit pop, have, drop;
    logic [15:0] w;
    logic [7:0]  win;
    pop  = (m_q.size() > 0) && out_ready;
    have = 1'b0;
    drop = 1'b0;
    w    = 16'h0000;
    if (bit_en) begin
      if (!m_coll) begin
        m_hist.push_back(serial_in);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        if (m_hist.size() == 8) begin
          for (int i = 0; i < 8; i++) win[7-i] = m_hist[i];
          if (win == 8'hA5) begin
            m_coll = 1'b1;
            m_cnt  = 0;
            m_hist.delete();
          end
        end
      end else begin
        m_word = {m_word[14:0], serial_in};
        m_cnt++;
        if (m_cnt == 16) begin
          have   = 1'b1;
          w      = m_word;
          m_coll = 1'b0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (have) begin
      if (m_q.size() < 4) begin
        m_q.push_back(w);
        m_fcnt = (m_fcnt + 1) % 256;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("model_valid", out_valid, (m_q.size() != 0));
    chk("model_level", fifo_level, m_q.size());
    chk("model_ovf", overflow, m_ovf);
    chk("model_fcnt", frame_cnt, m_fcnt);
    if (m_q.size() != 0) chk("model_data", out_data, m_q[0]);
  endtask

  task automatic idle();
    bit_en = 1'b0;
    if (rnd_mode) begin
      serial_in = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
    end
    tick();
  endtask

  // Send n bits of v, MSB first; gapped inserts two idle cycles between bits.
  task automatic send_bits(input logic [31:0] v, input int n, input bit gapped);
    for (int i = n - 1; i >= 0; i--) begin
      if (gapped && i != n - 1) begin
        idle();
        idle();
      end
      if (rnd_mode) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) idle();
        out_ready = ($urandom_range(0, 3) == 0);
        clr_ovf   = ($urandom_range(0, 15) == 0);
      end
      bit_en    = 1'b1;
      serial_in = v[i];
      tick();
      bit_en = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_data"}, out_data, 16'h0000);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_fcnt"}, frame_cnt, 8'd0);
    chk({tag, "_level"}, fifo_level, 3'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, released away from the clock edge.
  task automatic do_reset(input string tag);
    bit_en  = 1'b0;
    clr_ovf = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    bit          gapped;
    bit          emit;
    logic [15:0] word;
    logic [7:0]  fcnt;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] exp_drain[4];

  initial begin
    checks = 0;
    errors = 0;
    rnd_mode  = 1'b0;
    rst       = 1'b0;
    serial_in = 1'b0;
    bit_en    = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    model_clear();

    vecs[0] = '{{8'h00, 8'hA5, 16'h1234}, 24, 1'b0, 1'b1, 16'h1234, 8'd1};
    vecs[1] = '{{5'b00000, 3'b101, 8'hA5, 16'hBEEF}, 27, 1'b0, 1'b1, 16'hBEEF, 8'd2};
    vecs[2] = '{{16'h0000, 16'h0F0F}, 16, 1'b0, 1'b0, 16'h0000, 8'd2};
    vecs[3] = '{{8'h00, 8'hA5, 16'h1234}, 24, 1'b1, 1'b1, 16'h1234, 8'd3};

    #3;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int v = 0; v < 4; v++) begin
      out_ready = 1'b1;
      send_bits(vecs[v].bits, vecs[v].nbits, vecs[v].gapped);
      chk($sformatf("vec%0d_valid", v), out_valid, vecs[v].emit);
      if (vecs[v].emit) chk($sformatf("vec%0d_data", v), out_data, vecs[v].word);
      chk($sformatf("vec%0d_fcnt", v), frame_cnt, vecs[v].fcnt);
      idle();
      chk($sformatf("vec%0d_popped", v), out_valid, 1'b0);
    end

    // Backpressure: five frames into a four-entry FIFO.
    do_reset("rst1");
    out_ready = 1'b0;
    for (int f = 1; f <= 5; f++) send_bits({8'h00, 8'hA5, 16'(f)}, 24, 1'b0);
    chk("bp_level", fifo_level, 3'd4);
    chk("bp_ovf", overflow, 1'b1);
    chk("bp_fcnt", frame_cnt, 8'd4);
    chk("bp_head", out_data, 16'h0001);
    clr_ovf = 1'b1;
    idle();
    clr_ovf = 1'b0;
    chk("clr_ovf", overflow, 1'b0);

    // Last bit of 0006 coincides with a pop while full.
    send_bits({9'h000, 8'hA5, 15'h0003}, 23, 1'b0);
    out_ready = 1'b1;
    bit_en    = 1'b1;
    serial_in = 1'b0;
    tick();
    bit_en    = 1'b0;
    out_ready = 1'b0;
    chk("fullpop_level", fifo_level, 3'd4);
    chk("fullpop_ovf", overflow, 1'b0);
    chk("fullpop_fcnt", frame_cnt, 8'd5);
    exp_drain = '{16'h0002, 16'h0003, 16'h0004, 16'h0006};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("drain%0d_data", k), out_data, exp_drain[k]);
      idle();
    end
    chk("drain_empty", out_valid, 1'b0);

    // Reset in the middle of a payload.
    send_bits({8'h00, 8'hA5, 8'h12}, 16, 1'b0);
    do_reset("rst2");
    send_bits({8'h00, 8'hA5, 16'hCAFE}, 24, 1'b0);
    chk("cafe_valid", out_valid, 1'b1);
    chk("cafe_data", out_data, 16'hCAFE);
    chk("cafe_fcnt", frame_cnt, 8'd1);
    idle();

    // Randomized traffic with noise, gaps, backpressure and clears.
    rnd_mode = 1'b1;
    for (int it = 0; it < 80; it++) begin
      send_bits($urandom, $urandom_range(0, 12), 1'b0);
      send_bits({8'h00, 8'hA5, 16'($urandom)}, 24, 1'b0);
    end
    rnd_mode  = 1'b0;
    out_ready = 1'b1;
    clr_ovf   = 1'b0;
    for (int k = 0; k < 6; k++) idle();
    chk("final_empty", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
